traffic_light_seq_master: RTL and testbench

//  Avalon-MM master that drives the traffic-light 3-bit output PIO slave.

---
 rtl/traffic_light_seq_master_pkg.sv | 55 +++++
 rtl/traffic_light_seq_master_if.sv | 42 ++++
 rtl/traffic_light_seq_master_dwell_timer.sv | 39 +++
 rtl/traffic_light_seq_master.sv | 238 +++++++++++++++++++++++
 tb/tb_traffic_light_seq_master.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_seq_master_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_pkg
// Shared types and helpers for the traffic-light sequencing Avalon-MM master:
//   phase_t        lamp phase encoding (also the value reported on o_phase)
//   LAMP_*         one-hot lamp patterns written to the PIO data register
//   state_t        master FSM states (RB only exists when TL_SEQ_READBACK_EN
//                  is defined)
//   phase_to_lamps phase -> one-hot lamp pattern
//   next_phase     RED -> GREEN -> YELLOW -> RED
// -----------------------------------------------------------------------------
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } phase_t;

  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

`ifdef TL_SEQ_READBACK_EN
  typedef enum logic [1:0] {
    WR    = 2'd0,
    RB    = 2'd1,
    DWELL = 2'd2,
    PARK  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    WR    = 2'd0,
    DWELL = 2'd2,
    PARK  = 2'd3
  } state_t;
`endif

  // Any unexpected encoding maps to RED so the bus never sees 0 or multi-hot.
  function automatic logic [2:0] phase_to_lamps(input phase_t p);
    case (p)
      GREEN:   return LAMP_GREEN;
      YELLOW:  return LAMP_YELLOW;
      default: return LAMP_RED;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      RED:     return GREEN;
      GREEN:   return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_seq_master_if.sv
// -----------------------------------------------------------------------------
// traffic_light_seq_master_if
// Avalon-MM bundle between the traffic-light master and the lamp PIO slave.
//   avm_address     word address (master -> slave)
//   avm_chipselect  transaction strobe
//   avm_write_n     write strobe, active-low
//   avm_read_n      read strobe, active-low
//   avm_writedata   write data
//   avm_waitrequest slave stall (slave -> master)
//   avm_readdata    read data, valid in the accept cycle
// -----------------------------------------------------------------------------
interface traffic_light_seq_master_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic        avm_read_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_read_n,
    output avm_writedata,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_read_n,
    input  avm_writedata,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/traffic_light_seq_master_dwell_timer.sv
// -----------------------------------------------------------------------------
// tl_dwell_timer
// Up-counter for phase dwell. Held at zero while i_clr, increments while i_en,
// saturates at all-ones. o_tc flags the cycle in which the count equals i_last.
//   clk, reset_n  clock, async active-low reset
//   i_clr         synchronous clear (wins over i_en)
//   i_en          count enable
//   i_last        terminal count (dwell cycles - 1)
//   o_cnt         current count
//   o_tc          o_cnt == i_last
// -----------------------------------------------------------------------------
module tl_dwell_timer #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/traffic_light_seq_master.sv
// -----------------------------------------------------------------------------
// traffic_light_seq_master
// Avalon-MM master sequencing the lamp PIO RED -> GREEN -> YELLOW -> RED.
// Each lamp change is a single write of {29'b0, lamps} to PIO_ADDR; dwell per
// phase is timed by one tl_dwell_timer whose terminal count is muxed by phase.
// A latched pedestrian request may cut GREEN short once MIN_GREEN_CYCLES have
// elapsed. enable=0 forces a RED write and then parks with the bus idle.
//
// Optional build macro TL_SEQ_READBACK_EN: every write is followed by a read
// of PIO_ADDR; a lamp mismatch sets the sticky o_err. Without it avm_read_n is
// tied high and o_err tied low.
//
// Ports
//   clk, reset_n  clock, async active-low reset
//   i_enable      1 = run sequence, 0 = park on RED
//   i_ped_req     pedestrian request (level or pulse, latched)
//   avm           Avalon-MM master modport
//   o_phase       0=RED 1=GREEN 2=YELLOW, updated on write accept
//   o_busy        transaction outstanding (== chipselect)
//   o_err         sticky readback mismatch
//
// state | meaning
// WR    | write strobe up with r_lamps; wait for accept
// RB    | read-back of the lamp register (readback build only)
// DWELL | timing current phase
// PARK  | disabled, RED shown, bus idle
// -----------------------------------------------------------------------------
module traffic_light_seq_master
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_CYCLES       = 250_000_000,
  parameter int unsigned GREEN_CYCLES     = 200_000_000,
  parameter int unsigned YELLOW_CYCLES    = 50_000_000,
  parameter int unsigned MIN_GREEN_CYCLES = 50_000_000,
  parameter int unsigned CNT_W            = 28,
  parameter logic [1:0]  PIO_ADDR         = 2'd0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_enable,
  input  logic                              i_ped_req,
  traffic_light_seq_master_if.master        avm,
  output logic [1:0]                        o_phase,
  output logic                              o_busy,
  output logic                              o_err
);

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] MING_LAST   =
    (MIN_GREEN_CYCLES > 0) ? CNT_W'(MIN_GREEN_CYCLES - 1) : '0;

  state_t     r_state, w_state_nxt;
  phase_t     r_cur, w_cur_nxt;       // phase being written or dwelt
  phase_t     r_phase, w_phase_nxt;   // phase confirmed by the slave
  logic       r_cs, w_cs_nxt;
  logic       r_wr_n, w_wr_n_nxt;
  logic [2:0] r_lamps, w_lamps_nxt;
  logic       r_ped;

  logic             w_wr_acc;
  logic             w_launch;
  phase_t           w_launch_ph;
  state_t           w_done_state;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_ped_cut;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic             w_unused;

`ifdef TL_SEQ_READBACK_EN
  logic r_rd_n, w_rd_n_nxt;
  logic r_err, w_err_nxt;
  logic w_rd_acc;
  assign w_rd_acc = r_cs & ~r_rd_n & ~avm.avm_waitrequest;
`endif

  assign w_wr_acc = r_cs & ~r_wr_n & ~avm.avm_waitrequest;

  // A transaction finished while disabled: park only once RED is on the lamps,
  // otherwise DWELL sees enable=0 and issues the RED write next cycle.
  assign w_done_state = (!i_enable && (r_cur == RED)) ? PARK : DWELL;

  always_comb begin
    case (r_cur)
      RED:     w_last = RED_LAST;
      GREEN:   w_last = GREEN_LAST;
      default: w_last = YELLOW_LAST;
    endcase
  end

  assign w_tmr_clr = (r_state != DWELL);
  assign w_tmr_en  = (r_state == DWELL);

  tl_dwell_timer #(.CNT_W(CNT_W)) u_dwell_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_last  (w_last),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  assign w_ped_cut = (r_cur == GREEN) && r_ped && (w_cnt >= MING_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WR;
      r_cur   <= RED;
      r_phase <= RED;
      r_cs    <= 1'b0;
      r_wr_n  <= 1'b1;
      r_lamps <= 3'b000;
`ifdef TL_SEQ_READBACK_EN
      r_rd_n  <= 1'b1;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_phase <= w_phase_nxt;
      r_cs    <= w_cs_nxt;
      r_wr_n  <= w_wr_n_nxt;
      r_lamps <= w_lamps_nxt;
`ifdef TL_SEQ_READBACK_EN
      r_rd_n  <= w_rd_n_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_phase_nxt = r_phase;
    w_cs_nxt    = r_cs;
    w_wr_n_nxt  = r_wr_n;
    w_lamps_nxt = r_lamps;
`ifdef TL_SEQ_READBACK_EN
    w_rd_n_nxt  = r_rd_n;
    w_err_nxt   = r_err;
`endif
    w_launch    = 1'b0;
    w_launch_ph = RED;

    case (r_state)
      WR: begin
        // Strobe low in WR only happens right after reset.
        if (!r_cs) begin
          w_launch    = 1'b1;
          w_launch_ph = r_cur;
        end else if (w_wr_acc) begin
          w_phase_nxt = r_cur;
          w_wr_n_nxt  = 1'b1;
`ifdef TL_SEQ_READBACK_EN
          w_rd_n_nxt  = 1'b0;
          w_state_nxt = RB;
`else
          w_cs_nxt    = 1'b0;
          w_state_nxt = w_done_state;
`endif
        end
      end
`ifdef TL_SEQ_READBACK_EN
      RB: begin
        if (w_rd_acc) begin
          w_cs_nxt    = 1'b0;
          w_rd_n_nxt  = 1'b1;
          if (avm.avm_readdata[2:0] != r_lamps) begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = w_done_state;
        end
      end
`endif
      DWELL: begin
        if (!i_enable) begin
          w_launch    = 1'b1;
          w_launch_ph = RED;
        end else if (w_tc || w_ped_cut) begin
          w_launch    = 1'b1;
          w_launch_ph = next_phase(r_cur);
        end
      end
      PARK: begin
        if (i_enable) begin
          w_state_nxt = DWELL;
          w_cur_nxt   = RED;
        end
      end
      default: begin
        w_state_nxt = WR;
      end
    endcase

    // Strobes go up in the same cycle the decision is made: no idle cycle.
    if (w_launch) begin
      w_state_nxt = WR;
      w_cur_nxt   = w_launch_ph;
      w_cs_nxt    = 1'b1;
      w_wr_n_nxt  = 1'b0;
      w_lamps_nxt = phase_to_lamps(w_launch_ph);
    end
  end

  // Pedestrian latch; RED ignores requests, YELLOW accept consumes the latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ped <= 1'b0;
    end else if (w_wr_acc && (r_cur == YELLOW)) begin
      r_ped <= 1'b0;
    end else if (i_ped_req && (r_cur != RED)) begin
      r_ped <= 1'b1;
    end
  end

  assign avm.avm_address    = PIO_ADDR;
  assign avm.avm_chipselect = r_cs;
  assign avm.avm_write_n    = r_wr_n;
  assign avm.avm_writedata  = {29'b0, r_lamps};
  assign o_phase            = r_phase;
  assign o_busy             = r_cs;

`ifdef TL_SEQ_READBACK_EN
  assign avm.avm_read_n = r_rd_n;
  assign o_err          = r_err;
  assign w_unused       = ^avm.avm_readdata[31:3];
`else
  assign avm.avm_read_n = 1'b1;
  assign o_err          = 1'b0;
  assign w_unused       = ^avm.avm_readdata;
`endif

endmodule

// File: tb/tb_traffic_light_seq_master.sv
`timescale 1ns/1ps
module tb_traffic_light_seq_master;
  import traffic_light_pkg::*;

  localparam int RED_C  = 4;
  localparam int GREEN_C = 6;
  localparam int YEL_C  = 2;
  localparam int MING_C = 2;
`ifdef TL_SEQ_READBACK_EN
  localparam int RBX = 1;
`else
  localparam int RBX = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] phase;
  logic       busy;
  logic       err;
  logic [2:0] pio;
  logic       force_bad = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         g_cyc = 0;
  int         base = 0;

  traffic_light_seq_master_if bus();

  traffic_light_seq_master #(
    .RED_CYCLES       (RED_C),
    .GREEN_CYCLES     (GREEN_C),
    .YELLOW_CYCLES    (YEL_C),
    .MIN_GREEN_CYCLES (MING_C),
    .CNT_W            (8),
    .PIO_ADDR         (2'd0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_enable  (enable),
    .i_ped_req (ped_req),
    .avm       (bus),
    .o_phase   (phase),
    .o_busy    (busy),
    .o_err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) g_cyc <= g_cyc + 1;

  // PIO slave model: lamp register, zero-latency readdata
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pio <= 3'b000;
    else if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest)
      pio <= bus.avm_writedata[2:0];
  end
  assign bus.avm_readdata = force_bad ? 32'h0 : {29'b0, pio};

  task automatic do_reset();
    reset_n = 1'b0;
    ped_req = 1'b0;
    force_bad = 1'b0;
    bus.avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = g_cyc;
  endtask

  // Waits (bounded) for an accepted write; stamp is cycles since reset release.
  task automatic wait_write(input int budget, output logic [31:0] data,
                            output int stamp, output bit ok);
    ok = 1'b0; data = '0; stamp = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest) begin
        ok = 1'b1; data = bus.avm_writedata; stamp = g_cyc - base;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs: got %b want 0", bus.avm_chipselect); end
    n_checks++; if (bus.avm_write_n !== 1'b1) begin n_fail++; $display("FAIL rst_write_n: got %b want 1", bus.avm_write_n); end
    n_checks++; if (bus.avm_read_n !== 1'b1) begin n_fail++; $display("FAIL rst_read_n: got %b want 1", bus.avm_read_n); end
    n_checks++; if (bus.avm_address !== 2'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", bus.avm_address); end
    n_checks++; if (bus.avm_writedata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %0h want 0", bus.avm_writedata); end
    n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL rst_phase: got %0d want 0", phase); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_d [4] = '{32'h1, 32'h4, 32'h2, 32'h1};
    int          exp_s [4] = '{1, 6 + RBX, 13 + 2*RBX, 16 + 3*RBX};
    logic [1:0]  exp_p [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] d; int s; bit ok;
    logic [1:0]  prev;
    enable = 1'b1;
    do_reset();
    prev = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wait_write(30, d, s, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_timeout[%0d]: got none want write", i); end
      n_checks++; if (d !== exp_d[i]) begin n_fail++; $display("FAIL seq_data[%0d]: got %0h want %0h", i, d, exp_d[i]); end
      n_checks++; if (s !== exp_s[i]) begin n_fail++; $display("FAIL seq_cycle[%0d]: got %0d want %0d", i, s, exp_s[i]); end
      n_checks++; if (phase !== prev) begin n_fail++; $display("FAIL seq_phase_pre[%0d]: got %0d want %0d", i, phase, prev); end
      @(negedge clk);
      n_checks++; if (phase !== exp_p[i]) begin n_fail++; $display("FAIL seq_phase[%0d]: got %0d want %0d", i, phase, exp_p[i]); end
      prev = exp_p[i];
    end
  endtask

  task automatic test_waitrequest();
    logic [31:0] d; int s; bit ok; bit found;
    enable = 1'b1;
    do_reset();
    wait_write(30, d, s, ok);
    repeat (2) @(negedge clk);
    bus.avm_waitrequest = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.avm_chipselect) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL wr_stall_timeout: got no strobe want strobe"); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!(bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0 && bus.avm_writedata === 32'h4)) begin
        n_fail++; $display("FAIL wr_stall_hold[%0d]: got cs=%b wn=%b wd=%0h want cs=1 wn=0 wd=4", i, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata);
      end
      n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL wr_stall_phase[%0d]: got %0d want 0", i, phase); end
      if (i == 3) bus.avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (phase !== 2'd1) begin n_fail++; $display("FAIL wr_stall_phase_after: got %0d want 1", phase); end
  endtask

  task automatic test_ped();
    logic [31:0] d; int s, s_prev; bit ok;
    enable = 1'b1;
    do_reset();
    wait_write(30, d, s, ok);
    wait_write(30, d, s_prev, ok);
    repeat (1 + RBX) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_write(30, d, s, ok);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL ped_cut_data: got %0h want 2", d); end
    n_checks++; if (s - s_prev !== MING_C + 1 + RBX) begin n_fail++; $display("FAIL ped_cut_gap: got %0d want %0d", s - s_prev, MING_C + 1 + RBX); end
    wait_write(30, d, s_prev, ok);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ped_red_data: got %0h want 1", d); end
    repeat (1 + RBX) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_write(30, d, s_prev, ok);
    wait_write(30, d, s, ok);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL ped_ignored_data: got %0h want 2", d); end
    n_checks++; if (s - s_prev !== GREEN_C + 1 + RBX) begin n_fail++; $display("FAIL ped_ignored_gap: got %0d want %0d", s - s_prev, GREEN_C + 1 + RBX); end
  endtask

  task automatic test_enable();
    logic [31:0] d; int s, s_prev, t, n_busy; bit ok;
    enable = 1'b1;
    do_reset();
    wait_write(30, d, s, ok);
    wait_write(30, d, s_prev, ok);
    repeat (4 + RBX) @(negedge clk);
    enable = 1'b0;
    wait_write(30, d, s, ok);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL en_park_data: got %0h want 1", d); end
    n_checks++; if (s - s_prev !== 5 + RBX) begin n_fail++; $display("FAIL en_park_gap: got %0d want %0d", s - s_prev, 5 + RBX); end
    repeat (RBX) @(negedge clk);
    n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) n_busy++;
    end
    n_checks++; if (n_busy !== 0) begin n_fail++; $display("FAIL en_park_silent: got %0d busy cycles want 0", n_busy); end
    n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL en_park_phase: got %0d want 0", phase); end
    enable = 1'b1;
    t = g_cyc - base;
    wait_write(30, d, s, ok);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL en_resume_data: got %0h want 4", d); end
    n_checks++; if (s - t !== RED_C + 1) begin n_fail++; $display("FAIL en_resume_gap: got %0d want %0d", s - t, RED_C + 1); end
  endtask

  task automatic test_readback();
    logic [31:0] d; int s; bit ok;
    enable = 1'b1;
    do_reset();
`ifdef TL_SEQ_READBACK_EN
    wait_write(30, d, s, ok);
    @(negedge clk);
    n_checks++;
    if (!(bus.avm_chipselect === 1'b1 && bus.avm_read_n === 1'b0 && bus.avm_write_n === 1'b1)) begin
      n_fail++; $display("FAIL rb_read: got cs=%b rn=%b wn=%b want cs=1 rn=0 wn=1", bus.avm_chipselect, bus.avm_read_n, bus.avm_write_n);
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rb_err_pre: got %b want 0", err); end
    wait_write(30, d, s, ok);
    @(negedge clk);
    force_bad = 1'b1;
    @(negedge clk);
    force_bad = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rb_err_set: got %b want 1", err); end
    repeat (3) wait_write(30, d, s, ok);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rb_err_sticky: got %b want 1", err); end
`else
    begin
      int n_rd, n_err, n_wr;
      n_rd = 0; n_err = 0; n_wr = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.avm_read_n !== 1'b1) n_rd++;
        if (err !== 1'b0) n_err++;
        if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest) n_wr++;
      end
      n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL rb_off_read_n: got %0d low cycles want 0", n_rd); end
      n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL rb_off_err: got %0d set cycles want 0", n_err); end
      n_checks++; if (n_wr !== 8) begin n_fail++; $display("FAIL rb_off_writes: got %0d want 8", n_wr); end
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] d; int s; bit ok; bit found;
    enable = 1'b1;
    do_reset();
    wait_write(30, d, s, ok);
    repeat (2) @(negedge clk);
    bus.avm_waitrequest = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.avm_chipselect) found = 1'b1;
    end
    n_checks++; if (!(found && bus.avm_writedata === 32'h4)) begin n_fail++; $display("FAIL arst_stall: got wd=%0h want 4", bus.avm_writedata); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (bus.avm_chipselect !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_cs_drop: got cs=%b busy=%b want 0", bus.avm_chipselect, busy); end
    n_checks++; if (bus.avm_write_n !== 1'b1) begin n_fail++; $display("FAIL arst_wn_drop: got %b want 1", bus.avm_write_n); end
    n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL arst_phase: got %0d want 0", phase); end
    @(negedge clk);
    bus.avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    base = g_cyc;
    wait_write(30, d, s, ok);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL arst_first_data: got %0h want 1", d); end
    n_checks++; if (s !== 1) begin n_fail++; $display("FAIL arst_first_cycle: got %0d want 1", s); end
  endtask

  initial begin
    bus.avm_waitrequest = 1'b0;
    test_reset();
    test_sequence();
    test_waitrequest();
    test_ped();
    test_enable();
    test_readback();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
